// File: rtl/rmi_pkg.sv
// Shared constants for the RMI local-bus register bridge.
// Register offsets are relative to the bridge REG_BASE address.
package rmi_pkg;

    localparam int CTRL_OFS   = 0;
    localparam int LEN_L_OFS  = 1;
    localparam int LEN_H_OFS  = 2;
    localparam int STATUS_OFS = 3;
    localparam int USER_OFS   = 4;

    localparam int DONE_BIT = 0;
    localparam int OVF_BIT  = 1;

    localparam int LEN_W = 16;

    function automatic int reg_count(input int num_user);
        return USER_OFS + num_user;
    endfunction

endpackage

// File: rtl/rmi_frame_counter.sv
// Frame-length write counter with a sticky done flag.
// A wrap sets done and wins over a same-cycle write-1-to-clear.
module rmi_frame_counter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        clr,
    input  logic        w1c_done,
    input  logic [15:0] len,
    output logic        done,
    output logic        done_pulse
);

    logic [15:0] cnt;
    logic        wrap;

    assign wrap = inc && !clr && (len != 16'd0)
               && ((cnt + 16'd1) == len);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            if (clr || len == 16'd0) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= wrap ? 16'd0 : cnt + 16'd1;
            end
            if (wrap) begin
                done <= 1'b1;
            end else if (w1c_done) begin
                done <= 1'b0;
            end
            done_pulse <= wrap;
        end
    end

endmodule

// File: rtl/rmi_reg_bridge.sv
// Local-bus bridge: decodes strobed accesses into register-file
// accesses or SPRAM bank writes/reads, with frame counting and irq.
module rmi_reg_bridge
    import rmi_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] REG_BASE  = 16'h7FFF,
    parameter int                NUM_BANKS = 3,
    parameter int                NUM_USER  = 2,
    parameter logic [DATA_W-1:0] CTRL_RST  = 8'h12
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          lb_stb,
    input  logic                          lb_wren,
    input  logic [ADDR_W-1:0]             lb_addr,
    input  logic [DATA_W-1:0]             lb_wdata,
    output logic [DATA_W-1:0]             lb_rdata,
    output logic                          lb_ack,
    output logic [NUM_BANKS-1:0]          mem_wren,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]             o_ctrl,
    output logic [15:0]                   o_buffer_len,
    output logic [(NUM_USER > 0 ? NUM_USER : 1)*DATA_W-1:0] o_user,
    output logic                          o_frame_done,
    output logic                          o_irq
);

    localparam int NREG = reg_count(NUM_USER);
    localparam int UN   = (NUM_USER > 0) ? NUM_USER : 1;

    logic                 stb_d;
    logic                 start;
    logic [ADDR_W-1:0]    ofs;
    logic                 reg_hit;
    logic                 reg_wr;
    logic                 mem_wr;
    logic                 sel_ctrl;
    logic                 sel_len_l;
    logic                 sel_len_h;
    logic                 sel_status;

    logic [DATA_W-1:0]    ctrl;
    logic [DATA_W-1:0]    len_l;
    logic [DATA_W-1:0]    len_h;
    logic [15:0]          len;
    logic                 ovf;
    logic                 done;
    logic                 ovf_set;
    logic                 inc;
    logic                 len_clr;
    logic                 w1c_done;
    logic [DATA_W-1:0]    user_q [UN];
    logic [NUM_BANKS-1:0] bank_en;

    logic [DATA_W-1:0]    status_v;
    logic [DATA_W-1:0]    user_rd;
    logic [DATA_W-1:0]    reg_rd;
    logic [DATA_W-1:0]    bank_rd;

    logic                 pend;
    logic                 pend_hit;
    logic                 pend_wr;
    logic [NUM_BANKS-1:0] pend_en;
    logic [DATA_W-1:0]    rdata;

    assign start = lb_stb & ~stb_d;
    assign ofs   = lb_addr - REG_BASE;

    assign reg_hit = (lb_addr >= REG_BASE) && (ofs < ADDR_W'(NREG));
    assign reg_wr  = start & lb_wren & reg_hit;
    assign mem_wr  = start & lb_wren & ~reg_hit;

    assign sel_ctrl   = (ofs == ADDR_W'(CTRL_OFS));
    assign sel_len_l  = (ofs == ADDR_W'(LEN_L_OFS));
    assign sel_len_h  = (ofs == ADDR_W'(LEN_H_OFS));
    assign sel_status = (ofs == ADDR_W'(STATUS_OFS));

    assign bank_en  = ctrl[NUM_BANKS:1];
    assign mem_wren = {NUM_BANKS{mem_wr}} & bank_en;
    assign mem_addr  = lb_addr;
    assign mem_wdata = lb_wdata;

    assign inc      = |mem_wren;
    assign ovf_set  = mem_wr & ~(|bank_en);
    assign len_clr  = reg_wr & (sel_len_l | sel_len_h);
    assign w1c_done = reg_wr & sel_status & lb_wdata[DONE_BIT];
    assign len      = 16'({len_h, len_l});

    assign o_ctrl       = ctrl;
    assign o_buffer_len = len;
    assign o_irq        = done | ovf;

    always_comb begin
        status_v           = '0;
        status_v[DONE_BIT] = done;
        status_v[OVF_BIT]  = ovf;
    end

    always_comb begin
        user_rd = '0;
        for (int i = 0; i < NUM_USER; i++) begin
            if (ofs == ADDR_W'(USER_OFS + i)) begin
                user_rd = user_q[i];
            end
        end
    end

    always_comb begin
        reg_rd = '0;
        unique case (1'b1)
            sel_ctrl:   reg_rd = ctrl;
            sel_len_l:  reg_rd = len_l;
            sel_len_h:  reg_rd = len_h;
            sel_status: reg_rd = status_v;
            default:    reg_rd = user_rd;
        endcase
    end

    // Walk downward so the lowest enabled bank is the one left selected.
    always_comb begin
        bank_rd = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                bank_rd = mem_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_user = '0;
        for (int i = 0; i < NUM_USER; i++) begin
            o_user[i*DATA_W +: DATA_W] = user_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stb_d <= 1'b0;
            ctrl  <= CTRL_RST;
            len_l <= '0;
            len_h <= '0;
            ovf   <= 1'b0;
            for (int i = 0; i < UN; i++) begin
                user_q[i] <= '0;
            end
        end else begin
            stb_d <= lb_stb;
            if (reg_wr && sel_ctrl) begin
                ctrl <= lb_wdata;
            end
            if (reg_wr && sel_len_l) begin
                len_l <= lb_wdata;
            end
            if (reg_wr && sel_len_h) begin
                len_h <= lb_wdata;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (reg_wr && sel_status && lb_wdata[OVF_BIT]) begin
                ovf <= 1'b0;
            end
            for (int i = 0; i < NUM_USER; i++) begin
                if (reg_wr && ofs == ADDR_W'(USER_OFS + i)) begin
                    user_q[i] <= lb_wdata;
                end
            end
        end
    end

    // Two-stage response: capture in S, select data in S+1, ack in S+2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= 1'b0;
            pend_hit <= 1'b0;
            pend_wr  <= 1'b0;
            pend_en  <= '0;
            rdata    <= '0;
            lb_ack   <= 1'b0;
            lb_rdata <= '0;
        end else begin
            pend <= start;
            if (start) begin
                rdata    <= reg_rd;
                pend_hit <= reg_hit;
                pend_wr  <= lb_wren;
                pend_en  <= bank_en;
            end
            lb_ack <= pend;
            if (pend && !pend_wr) begin
                lb_rdata <= pend_hit ? rdata : bank_rd;
            end else begin
                lb_rdata <= '0;
            end
        end
    end

    rmi_frame_counter u_frame_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .inc        (inc),
        .clr        (len_clr),
        .w1c_done   (w1c_done),
        .len        (len),
        .done       (done),
        .done_pulse (o_frame_done)
    );

endmodule

// File: tb/tb_rmi_reg_bridge.sv
// Directed self-checking bench for rmi_reg_bridge.
// A second frame-counter instance exercises the set-vs-clear race.
module tb_rmi_reg_bridge;

    logic        clock;
    logic        reset_n;
    logic        lb_stb;
    logic        lb_wren;
    logic [15:0] lb_addr;
    logic [7:0]  lb_wdata;
    logic [7:0]  lb_rdata;
    logic        lb_ack;
    logic [2:0]  mem_wren;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [23:0] mem_rdata;
    logic [7:0]  o_ctrl;
    logic [15:0] o_buffer_len;
    logic [15:0] o_user;
    logic        o_frame_done;
    logic        o_irq;

    logic        fc_inc;
    logic        fc_clr;
    logic        fc_w1c;
    logic [15:0] fc_len;
    logic        fc_done;
    logic        fc_pulse;

    int checks;
    int errors;

    logic [2:0]  ob_wren;
    logic [2:0]  ob_wren1;
    logic [7:0]  ob_wdata;
    logic [15:0] ob_maddr;
    logic        ob_ack1;
    logic        ob_ack2;
    logic        ob_ack3;
    logic        ob_fd1;
    logic        ob_fd2;
    logic [7:0]  ob_rd;

    rmi_reg_bridge dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .lb_stb       (lb_stb),
        .lb_wren      (lb_wren),
        .lb_addr      (lb_addr),
        .lb_wdata     (lb_wdata),
        .lb_rdata     (lb_rdata),
        .lb_ack       (lb_ack),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .o_ctrl       (o_ctrl),
        .o_buffer_len (o_buffer_len),
        .o_user       (o_user),
        .o_frame_done (o_frame_done),
        .o_irq        (o_irq)
    );

    rmi_frame_counter fc (
        .clock      (clock),
        .reset_n    (reset_n),
        .inc        (fc_inc),
        .clr        (fc_clr),
        .w1c_done   (fc_w1c),
        .len        (fc_len),
        .done       (fc_done),
        .done_pulse (fc_pulse)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic access(input logic wr, input logic [15:0] a,
                          input logic [7:0] d);
        @(negedge clock);
        lb_stb   = 1'b1;
        lb_wren  = wr;
        lb_addr  = a;
        lb_wdata = d;
        #1;
        ob_wren  = mem_wren;
        ob_wdata = mem_wdata;
        ob_maddr = mem_addr;
        @(negedge clock);
        #1;
        ob_ack1  = lb_ack;
        ob_fd1   = o_frame_done;
        ob_wren1 = mem_wren;
        @(negedge clock);
        #1;
        ob_ack2 = lb_ack;
        ob_rd   = lb_rdata;
        ob_fd2  = o_frame_done;
        lb_stb  = 1'b0;
        @(negedge clock);
        #1;
        ob_ack3 = lb_ack;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (o_ctrl !== 8'h12 || o_irq !== 1'b0 || lb_ack !== 1'b0
            || o_frame_done !== 1'b0 || lb_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got ctrl=%h irq=%b ack=%b fd=%b rd=%h want 12 0 0 0 00",
                     o_ctrl, o_irq, lb_ack, o_frame_done, lb_rdata);
        end
        reset_n = 1'b1;
        access(1'b0, 16'h7FFF, 8'h00);
        checks++;
        if (ob_rd !== 8'h12) begin
            errors++;
            $display("FAIL reset_ctrl_read: got %h want 12", ob_rd);
        end
        checks++;
        if ({ob_ack1, ob_ack2, ob_ack3} !== 3'b010) begin
            errors++;
            $display("FAIL ack_timing: got %b want 010",
                     {ob_ack1, ob_ack2, ob_ack3});
        end
        access(1'b0, 16'h8002, 8'h00);
        checks++;
        if (ob_rd !== 8'h00 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got %h irq=%b want 00 irq=0",
                     ob_rd, o_irq);
        end
    endtask

    task automatic test_mem_write();
        access(1'b1, 16'h0010, 8'h55);
        checks++;
        if (ob_wren !== 3'b001 || ob_wdata !== 8'h55
            || ob_maddr !== 16'h0010) begin
            errors++;
            $display("FAIL wr_bank0: got wren=%b wd=%h a=%h want 001 55 0010",
                     ob_wren, ob_wdata, ob_maddr);
        end
        checks++;
        if (ob_wren1 !== 3'b000 || ob_ack2 !== 1'b1) begin
            errors++;
            $display("FAIL wr_pulse: got wren1=%b ack2=%b want 000 1",
                     ob_wren1, ob_ack2);
        end
        access(1'b1, 16'h7FFF, 8'h0E);
        access(1'b1, 16'h0011, 8'hAA);
        checks++;
        if (ob_wren !== 3'b111 || ob_fd1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_broadcast: got wren=%b fd=%b want 111 0",
                     ob_wren, ob_fd1);
        end
    endtask

    task automatic test_ovf();
        access(1'b1, 16'h7FFF, 8'h00);
        access(1'b1, 16'h0012, 8'h11);
        checks++;
        if (ob_wren !== 3'b000) begin
            errors++;
            $display("FAIL ovf_nowren: got %b want 000", ob_wren);
        end
        access(1'b0, 16'h8002, 8'h00);
        checks++;
        if (ob_rd !== 8'h02 || o_irq !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %h irq=%b want 02 irq=1", ob_rd, o_irq);
        end
        access(1'b1, 16'h8002, 8'h02);
        access(1'b0, 16'h8002, 8'h00);
        checks++;
        if (ob_rd !== 8'h00 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL ovf_w1c: got %h irq=%b want 00 irq=0", ob_rd, o_irq);
        end
    endtask

    task automatic test_frame();
        logic [5:0] exp_fd;
        exp_fd = 6'b100100;
        access(1'b1, 16'h8000, 8'h03);
        access(1'b1, 16'h8001, 8'h00);
        access(1'b1, 16'h7FFF, 8'h02);
        checks++;
        if (o_buffer_len !== 16'h0003) begin
            errors++;
            $display("FAIL len_reg: got %h want 0003", o_buffer_len);
        end
        for (int i = 0; i < 6; i++) begin
            access(1'b1, 16'h0100 + 16'(i), 8'(i));
            checks++;
            if (ob_fd1 !== exp_fd[i] || ob_fd2 !== 1'b0) begin
                errors++;
                $display("FAIL frame_done_w%0d: got %b%b want %b0",
                         i, ob_fd1, ob_fd2, exp_fd[i]);
            end
            if (i == 2) begin
                access(1'b0, 16'h8002, 8'h00);
                checks++;
                if (ob_rd !== 8'h01 || o_irq !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_status: got %h irq=%b want 01 1",
                             ob_rd, o_irq);
                end
            end
        end
        access(1'b1, 16'h0200, 8'h00);
        access(1'b1, 16'h8001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 16'h0210, 8'h00);
            checks++;
            if (ob_fd1 !== (i == 2)) begin
                errors++;
                $display("FAIL len_clr_w%0d: got %b want %b",
                         i, ob_fd1, (i == 2));
            end
        end
        access(1'b1, 16'h8002, 8'h01);
        access(1'b0, 16'h8002, 8'h00);
        checks++;
        if (ob_rd !== 8'h00 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL done_w1c: got %h irq=%b want 00 0", ob_rd, o_irq);
        end
    endtask

    task automatic test_read();
        mem_rdata = 24'hC3A75E;
        access(1'b1, 16'h7FFF, 8'h04);
        access(1'b0, 16'h0020, 8'h00);
        checks++;
        if (ob_rd !== 8'hA7 || ob_ack2 !== 1'b1) begin
            errors++;
            $display("FAIL rd_bank1: got %h ack=%b want A7 1", ob_rd, ob_ack2);
        end
        access(1'b0, 16'h7FFE, 8'h00);
        checks++;
        if (ob_rd !== 8'hA7) begin
            errors++;
            $display("FAIL rd_below_base: got %h want A7", ob_rd);
        end
        access(1'b1, 16'h7FFF, 8'h0E);
        access(1'b0, 16'h0021, 8'h00);
        checks++;
        if (ob_rd !== 8'h5E) begin
            errors++;
            $display("FAIL rd_lowest: got %h want 5E", ob_rd);
        end
        access(1'b1, 16'h7FFF, 8'h00);
        access(1'b0, 16'h8005, 8'h00);
        checks++;
        if (ob_rd !== 8'h00) begin
            errors++;
            $display("FAIL rd_nobank: got %h want 00", ob_rd);
        end
        access(1'b1, 16'h8003, 8'h3C);
        access(1'b1, 16'h8004, 8'h9D);
        access(1'b0, 16'h8003, 8'h00);
        checks++;
        if (ob_rd !== 8'h3C || o_user !== 16'h9D3C) begin
            errors++;
            $display("FAIL user_regs: got %h o_user=%h want 3C 9D3C",
                     ob_rd, o_user);
        end
    endtask

    task automatic test_held_strobe();
        int nw;
        int na;
        nw = 0;
        na = 0;
        access(1'b1, 16'h7FFF, 8'h02);
        @(negedge clock);
        lb_stb   = 1'b1;
        lb_wren  = 1'b1;
        lb_addr  = 16'h0030;
        lb_wdata = 8'h77;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (|mem_wren) nw++;
            if (lb_ack) na++;
            @(negedge clock);
            if (i == 5) lb_stb = 1'b0;
        end
        checks++;
        if (nw != 1 || na != 1) begin
            errors++;
            $display("FAIL held_strobe: got wren=%0d ack=%0d want 1 1", nw, na);
        end
    endtask

    task automatic test_w1c_race();
        @(negedge clock);
        fc_len = 16'd2;
        fc_inc = 1'b1;
        @(negedge clock);
        fc_w1c = 1'b1;
        #1;
        checks++;
        if (fc_done !== 1'b0) begin
            errors++;
            $display("FAIL race_pre: got %b want 0", fc_done);
        end
        @(negedge clock);
        fc_inc = 1'b0;
        fc_w1c = 1'b0;
        #1;
        checks++;
        if (fc_done !== 1'b1 || fc_pulse !== 1'b1) begin
            errors++;
            $display("FAIL race_set_wins: got done=%b pulse=%b want 1 1",
                     fc_done, fc_pulse);
        end
        @(negedge clock);
        fc_w1c = 1'b1;
        @(negedge clock);
        fc_w1c = 1'b0;
        #1;
        checks++;
        if (fc_done !== 1'b0) begin
            errors++;
            $display("FAIL race_clear: got %b want 0", fc_done);
        end
    endtask

    task automatic test_reset_mid();
        access(1'b1, 16'h7FFF, 8'h00);
        access(1'b1, 16'h0040, 8'h00);
        access(1'b1, 16'h8000, 8'h05);
        access(1'b1, 16'h7FFF, 8'h0E);
        @(negedge clock);
        lb_stb  = 1'b1;
        lb_wren = 1'b0;
        lb_addr = 16'h7FFF;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_ctrl !== 8'h12 || o_irq !== 1'b0 || lb_ack !== 1'b0
            || o_user !== 16'h0000 || o_buffer_len !== 16'h0000
            || lb_rdata !== 8'h00 || o_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ctrl=%h irq=%b ack=%b user=%h len=%h rd=%h want 12 0 0 0000 0000 00",
                     o_ctrl, o_irq, lb_ack, o_user, o_buffer_len, lb_rdata);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        ob_ack1 = lb_ack;
        @(negedge clock);
        #1;
        ob_ack2 = lb_ack;
        ob_rd   = lb_rdata;
        lb_stb  = 1'b0;
        @(negedge clock);
        #1;
        ob_ack3 = lb_ack;
        checks++;
        if ({ob_ack1, ob_ack2, ob_ack3} !== 3'b010 || ob_rd !== 8'h12) begin
            errors++;
            $display("FAIL post_reset_start: got ack=%b rd=%h want 010 12",
                     {ob_ack1, ob_ack2, ob_ack3}, ob_rd);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        lb_stb    = 1'b0;
        lb_wren   = 1'b0;
        lb_addr   = 16'h0000;
        lb_wdata  = 8'h00;
        mem_rdata = 24'h000000;
        fc_inc    = 1'b0;
        fc_clr    = 1'b0;
        fc_w1c    = 1'b0;
        fc_len    = 16'd0;
        test_reset();
        test_mem_write();
        test_ovf();
        test_frame();
        test_read();
        test_held_strobe();
        test_w1c_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
